// File: rtl/position_registers.sv
// position_registers: 3x3 tic-tac-toe board store, one mark committed per accepted move
//   clock, reset      : single clock, synchronous active-high reset (clears the board)
//   XO_turn           : side to move, 0 = X (writes X_CODE), 1 = O (writes O_CODE)
//   illegal_move      : blocks every write this cycle
//   ply_En_pos[8:0]   : one-hot cell select, bit i-1 selects pos_i
//   pos1..pos9        : registered cell codes (EMPTY / X_CODE / O_CODE), row-major
//   occupied, board_full : status outputs, present only with `define POS_STATUS_EN
module position_registers #(
    parameter logic [1:0] X_CODE = 2'b01,
    parameter logic [1:0] O_CODE = 2'b10,
    parameter logic [1:0] EMPTY  = 2'b00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       XO_turn,
    input  logic       illegal_move,
    input  logic [8:0] ply_En_pos,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9
`ifdef POS_STATUS_EN
    ,
    output logic [8:0] occupied,
    output logic       board_full
`endif
);
    logic [8:0][1:0] cells;
    logic [8:0]      empty;
    logic            one_hot;
    logic            we;
    always_comb begin
        for (int i = 0; i < 9; i++) empty[i] = cells[i] == EMPTY;
    end
    // a multi-hot or zero select is not a move; with a one-hot select the AND picks the target cell
    assign one_hot = (ply_En_pos != 9'd0) && ((ply_En_pos & (ply_En_pos - 9'd1)) == 9'd0);
    assign we      = !illegal_move && one_hot && ((ply_En_pos & empty) != 9'd0);
    always_ff @(posedge clock) begin
        if (reset)
            cells <= {9{EMPTY}};
        else if (we)
            for (int i = 0; i < 9; i++)
                if (ply_En_pos[i]) cells[i] <= XO_turn ? O_CODE : X_CODE;
    end
    assign {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1} = cells;
`ifdef POS_STATUS_EN
    assign occupied   = ~empty;
    assign board_full = &occupied;
`endif
endmodule

// File: tb/tb_position_registers.sv
// tb_position_registers: directed table, held-input sequence and randomized model check of position_registers
module tb_position_registers;
    logic       clock = 0;
    logic       reset, XO_turn, illegal_move;
    logic [8:0] ply_En_pos;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
`ifdef POS_STATUS_EN
    logic [8:0] occupied;
    logic       board_full;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    position_registers dut (
        .clock(clock), .reset(reset), .XO_turn(XO_turn), .illegal_move(illegal_move),
        .ply_En_pos(ply_En_pos),
        .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
        .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9)
`ifdef POS_STATUS_EN
        , .occupied(occupied), .board_full(board_full)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        ill;
        logic        turn;
        logic [8:0]  sel;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[14];
    int   model[9];

    function automatic logic [17:0] board();
        return {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
    endfunction

    function automatic logic [17:0] model_board();
        logic [17:0] b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(model[i]);
        return b;
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ill, input logic turn, input logic [8:0] sel);
        reset = rst; illegal_move = ill; XO_turn = turn; ply_En_pos = sel;
        @(posedge clock);
        #1;
    endtask

    // reference: a legal move is exactly one selected cell, not rejected, landing on an empty cell
    task automatic model_step(input logic rst, input logic ill, input logic turn, input logic [8:0] sel);
        if (rst) begin
            for (int i = 0; i < 9; i++) model[i] = 0;
        end else if (!ill && $countones(sel) == 1) begin
            for (int i = 0; i < 9; i++)
                if (sel[i] && model[i] == 0) model[i] = turn ? 2 : 1;
        end
    endtask

`ifdef POS_STATUS_EN
    task automatic check_status(input string name);
        logic [8:0] occ = '0;
        for (int i = 0; i < 9; i++) occ[i] = model[i] != 0;
        check({name, "_occupied"}, 18'(occupied), 18'(occ));
        check({name, "_full"}, 18'(board_full), 18'(&occ));
    endtask
`endif

    initial begin
        vecs[0]  = '{1, 0, 0, 9'h000, 18'h00000};
        vecs[1]  = '{1, 0, 0, 9'h000, 18'h00000};
        vecs[2]  = '{0, 0, 0, 9'h001, 18'h00001};
        vecs[3]  = '{0, 0, 0, 9'h002, 18'h00005};
        vecs[4]  = '{0, 0, 0, 9'h004, 18'h00015};
        vecs[5]  = '{0, 0, 0, 9'h008, 18'h00055};
        vecs[6]  = '{0, 0, 1, 9'h100, 18'h20055};
        vecs[7]  = '{0, 0, 0, 9'h100, 18'h20055};
        vecs[8]  = '{0, 1, 0, 9'h010, 18'h20055};
        vecs[9]  = '{0, 0, 0, 9'h010, 18'h20155};
        vecs[10] = '{0, 0, 0, 9'h003, 18'h20155};
        vecs[11] = '{0, 0, 1, 9'h000, 18'h20155};
        vecs[12] = '{1, 0, 0, 9'h020, 18'h00000};
        vecs[13] = '{0, 0, 1, 9'h040, 18'h02000};
        reset = 1; illegal_move = 0; XO_turn = 0; ply_En_pos = '0;
        for (int k = 0; k < 14; k++) begin
            step(vecs[k].rst, vecs[k].ill, vecs[k].turn, vecs[k].sel);
            check($sformatf("vec%0d", k), board(), vecs[k].exp);
        end

        // held select: only the first edge writes, later turn flips leave pos8 alone
        step(0, 0, 0, 9'h080);
        check("held_first", board(), 18'h06000);
        step(0, 0, 1, 9'h080);
        check("held_turn1", board(), 18'h06000);
        step(0, 0, 0, 9'h080);
        check("held_turn0", board(), 18'h06000);

        // fill the board alternating sides, then clear it
        for (int i = 0; i < 9; i++) model[i] = 0;
        step(1, 0, 0, 9'h000);
        for (int i = 0; i < 9; i++) begin
            model_step(0, 0, 1'(i), 9'(1 << i));
            step(0, 0, 1'(i), 9'(1 << i));
        end
        check("fill", board(), model_board());
`ifdef POS_STATUS_EN
        check_status("fill");
`endif
        model_step(1, 0, 0, 9'h000);
        step(1, 0, 0, 9'h000);
        check("fill_reset", board(), 18'h00000);
`ifdef POS_STATUS_EN
        check_status("fill_reset");
`endif

        for (int n = 0; n < 400; n++) begin
            logic       r, il, t;
            logic [8:0] s;
            int         kind;
            r    = $urandom_range(0, 29) == 0;
            il   = $urandom_range(0, 4) == 0;
            t    = 1'($urandom);
            kind = $urandom_range(0, 9);
            s    = kind == 0 ? 9'h000 : kind < 3 ? 9'($urandom) : 9'(1 << $urandom_range(0, 8));
            model_step(r, il, t, s);
            step(r, il, t, s);
            check($sformatf("rand%0d", n), board(), model_board());
`ifdef POS_STATUS_EN
            check_status($sformatf("rand%0d", n));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
